// File: rtl/nukv_stream_packer.sv
// Packs PACK_RATIO consecutive narrow stream words into one wide output word.
// A partial word leaves on an explicit flush or after an idle timeout.
module nukv_stream_packer #(
  parameter int DATA_SIZE      = 16,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int LANE_BITS      = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_SIZE-1:0]             s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             flush,
  output logic [DATA_SIZE*PACK_RATIO-1:0]  m_axis_tdata,
  output logic [LANE_BITS-1:0]             m_axis_tlanes,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [31:0]                      packed_count
);

  localparam int                   OUT_W    = DATA_SIZE * PACK_RATIO;
  localparam logic [LANE_BITS-1:0] FULL_CNT = LANE_BITS'(PACK_RATIO);
  localparam logic [LANE_BITS-1:0] ZERO_CNT = {LANE_BITS{1'b0}};
  localparam logic [31:0]          TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam bit                   TMO_EN   = (TIMEOUT_CYCLES > 0);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                               state_q, state_d;
  logic [PACK_RATIO-1:0][DATA_SIZE-1:0] acc_q, acc_d;
  logic [LANE_BITS-1:0]                 acc_cnt_q, acc_cnt_d;
  logic [31:0]                          tmo_q, tmo_d;
  logic [OUT_W-1:0]                     out_data_q, out_data_d;
  logic [LANE_BITS-1:0]                 out_lanes_q, out_lanes_d;
  logic                                 out_valid_q, out_valid_d;
  logic [31:0]                          pcount_q, pcount_d;

  logic             out_free_s;
  logic             s_ready_s;
  logic             accept_s;
  logic             full_move_s;
  logic             part_move_s;
  logic             cnt_partial_s;
  logic             next_partial_s;
  logic             tmo_fire_s;
  logic [OUT_W-1:0] masked_s;

  assign out_free_s     = !out_valid_q || m_axis_tready;
  assign accept_s       = s_axis_tvalid && s_ready_s;
  assign cnt_partial_s  = (acc_cnt_q != ZERO_CNT) && (acc_cnt_q < FULL_CNT);
  assign next_partial_s = (acc_cnt_d != ZERO_CNT) && (acc_cnt_d < FULL_CNT);
  assign tmo_fire_s     = TMO_EN && (state_q == ST_ACCUM) && !accept_s &&
                          cnt_partial_s && (tmo_q == TMO_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush is judged on the count after this cycle's accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if ((flush && next_partial_s) || tmo_fire_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_FLUSH: begin
        if (part_move_s) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // FSM outputs: input ready and which kind of move to the output register
  always_comb begin
    s_ready_s   = 1'b0;
    full_move_s = 1'b0;
    part_move_s = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        s_ready_s   = rst && ((acc_cnt_q < FULL_CNT) || out_free_s);
        full_move_s = (acc_cnt_q == FULL_CNT) && out_free_s;
      end
      ST_FLUSH: begin
        part_move_s = out_free_s;
      end
      default: begin
        s_ready_s   = 1'b0;
        full_move_s = 1'b0;
        part_move_s = 1'b0;
      end
    endcase
  end

  assign s_axis_tready = s_ready_s;

  // Accumulator next state; a move frees the lanes so a new word lands in lane 0
  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (full_move_s) begin
      if (accept_s) begin
        acc_d[0]  = s_axis_tdata;
        acc_cnt_d = LANE_BITS'(1);
      end else begin
        acc_cnt_d = ZERO_CNT;
      end
    end else if (part_move_s) begin
      acc_cnt_d = ZERO_CNT;
    end else if (accept_s) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (LANE_BITS'(i) == acc_cnt_q) begin
          acc_d[i] = s_axis_tdata;
        end else begin
          acc_d[i] = acc_q[i];
        end
      end
      acc_cnt_d = acc_cnt_q + LANE_BITS'(1);
    end else begin
      acc_cnt_d = acc_cnt_q;
    end
  end

  // Partial word with lanes beyond the fill level forced to zero
  always_comb begin
    masked_s = {OUT_W{1'b0}};
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (LANE_BITS'(i) < acc_cnt_q) begin
        masked_s[i*DATA_SIZE +: DATA_SIZE] = acc_q[i];
      end else begin
        masked_s[i*DATA_SIZE +: DATA_SIZE] = {DATA_SIZE{1'b0}};
      end
    end
  end

  // Idle timeout counter, only runs on a partial word that stays in ACCUM
  always_comb begin
    if (TMO_EN && (state_q == ST_ACCUM) && (state_d == ST_ACCUM) &&
        !accept_s && cnt_partial_s) begin
      tmo_d = tmo_q + 32'd1;
    end else begin
      tmo_d = 32'd0;
    end
  end

  // Output register next state and transfer counter
  always_comb begin
    out_data_d  = out_data_q;
    out_lanes_d = out_lanes_q;
    out_valid_d = out_valid_q;
    if (full_move_s) begin
      out_data_d  = acc_q;
      out_lanes_d = FULL_CNT;
      out_valid_d = 1'b1;
    end else if (part_move_s) begin
      out_data_d  = masked_s;
      out_lanes_d = acc_cnt_q;
      out_valid_d = 1'b1;
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (out_valid_q && m_axis_tready) begin
      pcount_d = pcount_q + 32'd1;
    end else begin
      pcount_d = pcount_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q       <= {(PACK_RATIO*DATA_SIZE){1'b0}};
      acc_cnt_q   <= ZERO_CNT;
      tmo_q       <= 32'd0;
      out_data_q  <= {OUT_W{1'b0}};
      out_lanes_q <= ZERO_CNT;
      out_valid_q <= 1'b0;
      pcount_q    <= 32'd0;
    end else begin
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      tmo_q       <= tmo_d;
      out_data_q  <= out_data_d;
      out_lanes_q <= out_lanes_d;
      out_valid_q <= out_valid_d;
      pcount_q    <= pcount_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlanes = out_lanes_q;
  assign m_axis_tvalid = out_valid_q;
  assign packed_count  = pcount_q;

endmodule

// File: tb/tb_nukv_stream_packer.sv
// Bench for nukv_stream_packer: directed scenarios plus a randomized run
// against a queue-based grouping model.
module tb_nukv_stream_packer;

  localparam int DS  = 16;
  localparam int PR  = 4;
  localparam int TMO = 8;
  localparam int LB  = 3;
  localparam int OW  = DS * PR;

  typedef logic [LB+OW-1:0] item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DS-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          flush = 1'b0;
  logic [OW-1:0] m_axis_tdata;
  logic [LB-1:0] m_axis_tlanes;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [31:0]   packed_count;

  nukv_stream_packer #(
    .DATA_SIZE(DS), .PACK_RATIO(PR), .TIMEOUT_CYCLES(TMO), .LANE_BITS(LB)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .flush(flush),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlanes(m_axis_tlanes),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .packed_count(packed_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  item_t         exp_q[$];
  item_t         got_q[$];
  logic [DS-1:0] grp[$];
  int            idle  = 0;
  int            xfers = 0;

  logic          smp_tready, smp_mvalid, last_acc;
  logic [OW-1:0] smp_mdata;
  logic [LB-1:0] smp_mlanes;
  logic [31:0]   smp_pc;

  // Close the current group into an expected output word
  function automatic void emit();
    item_t it;
    it = '0;
    for (int i = 0; i < grp.size(); i++) it[i*DS +: DS] = grp[i];
    it[OW +: LB] = LB'(grp.size());
    exp_q.push_back(it);
    grp.delete();
    idle = 0;
  endfunction

  // One clock: drive, sample mid-cycle, update the model, advance
  task automatic step(input logic rn, input logic v, input logic [DS-1:0] d,
                      input logic f, input logic mr);
    @(negedge clk);
    rst = rn; s_axis_tvalid = v; s_axis_tdata = d; flush = f; m_axis_tready = mr;
    #1;
    smp_tready = s_axis_tready;
    smp_mvalid = m_axis_tvalid;
    smp_mdata  = m_axis_tdata;
    smp_mlanes = m_axis_tlanes;
    smp_pc     = packed_count;
    last_acc   = v && smp_tready;
    if (!rn) begin
      grp.delete(); exp_q.delete(); got_q.delete();
      idle = 0; xfers = 0;
    end else begin
      if (smp_mvalid && mr) begin
        got_q.push_back({smp_mlanes, smp_mdata});
        xfers++;
      end
      if (last_acc) begin
        grp.push_back(d);
        idle = 0;
        if (grp.size() == PR) emit();
      end else if (grp.size() > 0) begin
        idle++;
      end
      if (f && grp.size() > 0) emit();
      else if (idle >= TMO) emit();
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (smp_mvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", smp_mvalid); end
    checks++; if (smp_mdata !== 64'd0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", smp_mdata); end
    checks++; if (smp_mlanes !== 3'd0) begin failures++; $display("FAIL reset_tlanes got=%0d exp=0", smp_mlanes); end
    checks++; if (smp_pc !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", smp_pc); end
    checks++; if (smp_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", smp_tready); end
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (smp_tready !== 1'b1) begin failures++; $display("FAIL post_reset_tready got=%b exp=1", smp_tready); end
  endtask

  task automatic test_back_to_back();
    int    first = -1;
    int    drops = 0;
    item_t e0, e1;
    e0 = {3'd4, 64'h0004_0003_0002_0001};
    e1 = {3'd4, 64'h0008_0007_0006_0005};
    for (int k = 0; k < 14; k++) begin
      step(1'b1, k < 8, 16'(k + 1), 1'b0, 1'b1);
      if (k < 8 && !smp_tready) drops++;
      if (smp_mvalid && first < 0) first = k;
    end
    checks++; if (drops !== 0) begin failures++; $display("FAIL b2b_tready_drops got=%0d exp=0", drops); end
    checks++; if (first !== 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", first); end
    checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== e0) begin failures++; $display("FAIL b2b_word0 got=%h exp=%h", got_q[0], e0); end
      checks++; if (got_q[1] !== e1) begin failures++; $display("FAIL b2b_word1 got=%h exp=%h", got_q[1], e1); end
    end
    checks++; if (smp_pc !== 32'd2) begin failures++; $display("FAIL b2b_packed_count got=%0d exp=2", smp_pc); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int    nxt = 0;
    int    unstable = 0;
    item_t held, e;
    held = {3'd4, 64'h0A03_0A02_0A01_0A00};
    for (int c = 0; c < 12; c++) begin
      step(1'b1, nxt < 12, 16'(16'h0A00 + nxt), 1'b0, 1'b0);
      if (last_acc) nxt++;
      if (smp_mvalid && {smp_mlanes, smp_mdata} !== held) unstable++;
    end
    checks++; if (nxt !== 8) begin failures++; $display("FAIL bp_accepts got=%0d exp=8", nxt); end
    checks++; if (smp_tready !== 1'b0) begin failures++; $display("FAIL bp_tready got=%b exp=0", smp_tready); end
    checks++; if (smp_mvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid got=%b exp=1", smp_mvalid); end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_hold_stable got=%0d exp=0", unstable); end
    for (int c = 0; c < 30; c++) begin
      step(1'b1, nxt < 12, 16'(16'h0A00 + nxt), 1'b0, 1'b1);
      if (last_acc) nxt++;
    end
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL bp_out_count got=%0d exp=3", got_q.size()); end
    for (int g = 0; g < 3 && g < got_q.size(); g++) begin
      e = '0;
      for (int l = 0; l < PR; l++) e[l*DS +: DS] = 16'(16'h0A00 + g*PR + l);
      e[OW +: LB] = 3'd4;
      checks++; if (got_q[g] !== e) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", g, got_q[g], e); end
    end
    checks++; if (smp_pc !== 32'd5) begin failures++; $display("FAIL bp_packed_count got=%0d exp=5", smp_pc); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush();
    logic [5:0] rdy;
    item_t      e;
    e = {3'd2, 64'h0000_0000_BBBB_AAAA};
    step(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    rdy[0] = smp_tready;
    for (int s = 1; s < 6; s++) begin
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      rdy[s] = smp_tready;
    end
    checks++; if (rdy !== 6'b111101) begin failures++; $display("FAIL flush_tready got=%b exp=111101", rdy); end
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== e) begin failures++; $display("FAIL flush_word got=%h exp=%h", got_q[0], e); end
    end
    checks++; if (smp_pc !== 32'd6) begin failures++; $display("FAIL flush_packed_count got=%0d exp=6", smp_pc); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    int    first = -1;
    logic  rdy9 = 1'b1;
    int    spurious = 0;
    item_t e;
    e = {3'd1, 64'h0000_0000_0000_1234};
    step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
    for (int s = 1; s < 15; s++) begin
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      if (s == 9) rdy9 = smp_tready;
      if (smp_mvalid && first < 0) first = s;
    end
    checks++; if (first !== 10) begin failures++; $display("FAIL tmo_latency got=%0d exp=10", first); end
    checks++; if (rdy9 !== 1'b0) begin failures++; $display("FAIL tmo_flush_tready got=%b exp=0", rdy9); end
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL tmo_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== e) begin failures++; $display("FAIL tmo_word got=%h exp=%h", got_q[0], e); end
    end
    got_q.delete(); exp_q.delete();
    for (int s = 0; s < 10; s++) begin
      step(1'b1, 1'b0, 16'h0000, s[0], 1'b1);
      if (smp_mvalid) spurious++;
    end
    checks++; if (spurious !== 0) begin failures++; $display("FAIL empty_flush_output got=%0d exp=0", spurious); end
    checks++; if (smp_pc !== 32'd7) begin failures++; $display("FAIL tmo_packed_count got=%0d exp=7", smp_pc); end
  endtask

  task automatic test_reset_mid();
    item_t e;
    e = {3'd4, 64'h0014_0013_0012_0011};
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'(16'h0050 + k), 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    checks++; if (smp_mvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid got=%b exp=0", smp_mvalid); end
    checks++; if (smp_mdata !== 64'd0) begin failures++; $display("FAIL rmid_tdata got=%h exp=0", smp_mdata); end
    checks++; if (smp_mlanes !== 3'd0) begin failures++; $display("FAIL rmid_tlanes got=%0d exp=0", smp_mlanes); end
    checks++; if (smp_pc !== 32'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", smp_pc); end
    for (int k = 0; k < 16; k++) step(1'b1, k < 4, 16'(16'h0011 + k), 1'b0, 1'b1);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL rmid_out_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== e) begin failures++; $display("FAIL rmid_word got=%h exp=%h", got_q[0], e); end
    end
    checks++; if (smp_pc !== 32'd1) begin failures++; $display("FAIL rmid_packed_count got=%0d exp=1", smp_pc); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int    words = 0;
    int    cyc = 0;
    logic  hold = 1'b0;
    item_t prev = '0;
    item_t g, x;
    logic  v, f, mr;
    xfers = 0;
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    while (words < 10000 && cyc < 80000) begin
      v  = ($urandom_range(3, 0) != 0);
      f  = ($urandom_range(39, 0) == 0);
      mr = ($urandom_range(2, 0) != 0);
      step(1'b1, v, 16'($urandom), f, mr);
      cyc++;
      if (last_acc) words++;
      if (hold && smp_mvalid) begin
        checks++;
        if ({smp_mlanes, smp_mdata} !== prev) begin
          failures++; $display("FAIL rnd_hold got=%h exp=%h", {smp_mlanes, smp_mdata}, prev);
        end
      end
      hold = smp_mvalid && !mr;
      prev = {smp_mlanes, smp_mdata};
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_extra_output got=%h exp=none", g);
        end else begin
          x = exp_q.pop_front();
          if (g !== x) begin failures++; $display("FAIL rnd_word got=%h exp=%h", g, x); end
        end
      end
    end
    for (int s = 0; s < 40; s++) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL rnd_extra_output got=%h exp=none", g);
      end else begin
        x = exp_q.pop_front();
        if (g !== x) begin failures++; $display("FAIL rnd_word got=%h exp=%h", g, x); end
      end
    end
    checks++; if (words !== 10000) begin failures++; $display("FAIL rnd_words got=%0d exp=10000", words); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_missing got=%0d exp=0", exp_q.size()); end
    checks++; if (smp_pc !== 32'(xfers)) begin failures++; $display("FAIL rnd_packed_count got=%0d exp=%0d", smp_pc, xfers); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
